// File: rtl/wb_queue.sv
// wb_queue: writeback queue between the result producers and the register file.
//
// Two producer channels (A: ALU, B: load) push results over valid/ready.
// Results are buffered in order in a DEPTH-entry circular FIFO. One entry
// retires per cycle onto the register-file write port. Two scoreboard query
// ports report whether a register still has a result pending.
//
// Ports:
//   clock, reset                  clock; synchronous active-low reset
//   a_valid/a_ready/a_address/a_data   channel A push handshake
//   b_valid/b_ready/b_address/b_data   channel B push handshake
//   write/write_address/write_data     register-file write port (head entry)
//   q1_address/q1_busy, q2_address/q2_busy   scoreboard queries
//   count                         occupied entries (0..DEPTH)
module wb_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [ADDR_W-1:0]        a_address,
    input  logic [DATA_W-1:0]        a_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [ADDR_W-1:0]        b_address,
    input  logic [DATA_W-1:0]        b_data,
    output logic                     write,
    output logic [ADDR_W-1:0]        write_address,
    output logic [DATA_W-1:0]        write_data,
    input  logic [ADDR_W-1:0]        q1_address,
    output logic                     q1_busy,
    input  logic [ADDR_W-1:0]        q2_address,
    output logic                     q2_busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Entry storage carries no reset; validity is tracked by head/count.
    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic [CNT_W-1:0]  w_free;
    logic              w_a_ready;
    logic              w_b_ready;
    logic              w_a_fire;
    logic              w_b_fire;
    logic              w_a_push;
    logic              w_b_push;
    logic [CNT_W-1:0]  w_pushes;
    logic [PTR_W-1:0]  w_b_slot;
    logic              w_write;
    logic              w_q1_hit;
    logic              w_q2_hit;

    // Space is judged from registered occupancy only; a retire this cycle
    // does not free a slot for this cycle's pushes.
    assign w_free    = DEPTH_C - r_count;
    assign w_a_ready = reset && (w_free != '0);
    // B may take the last slot only when A is not competing for it.
    assign w_b_ready = reset && ((w_free >= CNT_W'(2)) || ((w_free != '0) && !a_valid));

    assign w_a_fire  = a_valid && w_a_ready;
    assign w_b_fire  = b_valid && w_b_ready;
    // x0 results complete the handshake but are dropped.
    assign w_a_push  = w_a_fire && (a_address != '0);
    assign w_b_push  = w_b_fire && (b_address != '0);
    assign w_pushes  = CNT_W'(w_a_push) + CNT_W'(w_b_push);
    // B lands behind A when both are stored, so B is the younger entry.
    assign w_b_slot  = r_tail + PTR_W'(w_a_push);

    assign w_write   = reset && (r_count != '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_write) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_tail  <= r_tail + PTR_W'(w_pushes);
            r_count <= r_count + w_pushes - CNT_W'(w_write);
        end
    end

    always_ff @(posedge clock) begin
        if (w_a_push) begin
            r_mem_addr[r_tail] <= a_address;
            r_mem_data[r_tail] <= a_data;
        end
        if (w_b_push) begin
            r_mem_addr[w_b_slot] <= b_address;
            r_mem_data[w_b_slot] <= b_data;
        end
    end

    // Scoreboard: the head entry is skipped because the register file
    // forwards the write that is in flight this cycle.
    always_comb begin
        w_q1_hit = 1'b0;
        w_q2_hit = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            if (CNT_W'(i) < r_count) begin
                if (r_mem_addr[r_head + PTR_W'(i)] == q1_address) w_q1_hit = 1'b1;
                if (r_mem_addr[r_head + PTR_W'(i)] == q2_address) w_q2_hit = 1'b1;
            end
        end
        if (w_a_push && (a_address == q1_address)) w_q1_hit = 1'b1;
        if (w_b_push && (b_address == q1_address)) w_q1_hit = 1'b1;
        if (w_a_push && (a_address == q2_address)) w_q2_hit = 1'b1;
        if (w_b_push && (b_address == q2_address)) w_q2_hit = 1'b1;
    end

    assign a_ready       = w_a_ready;
    assign b_ready       = w_b_ready;
    assign write         = w_write;
    assign write_address = w_write ? r_mem_addr[r_head] : '0;
    assign write_data    = w_write ? r_mem_data[r_head] : '0;
    assign q1_busy       = reset && (q1_address != '0) && w_q1_hit;
    assign q2_busy       = reset && (q2_address != '0) && w_q2_hit;
    assign count         = reset ? r_count : '0;

endmodule

// File: tb/tb_wb_queue.sv
// Testbench for wb_queue: directed per-cycle vector table on a DEPTH=4
// instance, a held-valid fill sequence checked against a small queue model,
// and a DEPTH=2 instance to reach the full condition.
module tb_wb_queue;

    logic        clock;
    logic        reset;

    // DEPTH = 4 instance
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_address, b_address;
    logic [31:0] a_data, b_data;
    logic        write;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic [4:0]  q1_address, q2_address;
    logic        q1_busy, q2_busy;
    logic [2:0]  count;

    // DEPTH = 2 instance
    logic        d2_a_valid, d2_b_valid;
    logic        d2_a_ready, d2_b_ready;
    logic [4:0]  d2_a_address, d2_b_address;
    logic [31:0] d2_a_data, d2_b_data;
    logic        d2_write;
    logic [4:0]  d2_write_address;
    logic [31:0] d2_write_data;
    logic [4:0]  d2_q1_address, d2_q2_address;
    logic        d2_q1_busy, d2_q2_busy;
    logic [1:0]  d2_count;

    int n_tests = 0;
    int n_fail  = 0;

    wb_queue #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_address(a_address), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_address(b_address), .b_data(b_data),
        .write(write), .write_address(write_address), .write_data(write_data),
        .q1_address(q1_address), .q1_busy(q1_busy),
        .q2_address(q2_address), .q2_busy(q2_busy),
        .count(count)
    );

    wb_queue #(.DEPTH(2), .ADDR_W(5), .DATA_W(32)) dut2 (
        .clock(clock), .reset(reset),
        .a_valid(d2_a_valid), .a_ready(d2_a_ready), .a_address(d2_a_address), .a_data(d2_a_data),
        .b_valid(d2_b_valid), .b_ready(d2_b_ready), .b_address(d2_b_address), .b_data(d2_b_data),
        .write(d2_write), .write_address(d2_write_address), .write_data(d2_write_data),
        .q1_address(d2_q1_address), .q1_busy(d2_q1_busy),
        .q2_address(d2_q2_address), .q2_busy(d2_q2_busy),
        .count(d2_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst_n;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic [4:0]  q1;
        logic [4:0]  q2;
        logic        ew;
        logic [4:0]  ewa;
        logic [31:0] ewd;
        logic        ear;
        logic        ebr;
        logic        eq1;
        logic        eq2;
        logic [2:0]  ecnt;
    } vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } item_t;

    localparam int NVEC = 25;
    vec_t vt [NVEC];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_address = 0; a_data = 0;
        b_valid = 0; b_address = 0; b_data = 0;
        q1_address = 0; q2_address = 0;
        d2_a_valid = 0; d2_a_address = 0; d2_a_data = 0;
        d2_b_valid = 0; d2_b_address = 0; d2_b_data = 0;
        d2_q1_address = 0; d2_q2_address = 0;
    endtask

    task automatic d2_step(input string name,
                           input logic av, input logic [4:0] aa, input logic [31:0] ad,
                           input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                           input logic ear, input logic ebr, input logic ew,
                           input logic [4:0] ewa, input logic [31:0] ewd, input logic [1:0] ecnt);
        d2_a_valid = av; d2_a_address = aa; d2_a_data = ad;
        d2_b_valid = bv; d2_b_address = ba; d2_b_data = bd;
        #1;
        check(name, {22'd0, d2_a_ready, d2_b_ready, d2_write, d2_write_address, d2_write_data, d2_count},
                    {22'd0, ear, ebr, ew, ewa, ewd, ecnt});
        @(posedge clock); #1;
    endtask

    initial begin
        item_t q[$];
        item_t it;
        int    na, nb, pushed, retired, peak;
        logic  mar, mbr;
        int    cm;

        // Fields: rst_n, av,aa,ad, bv,ba,bd, q1,q2 | write,waddr,wdata, a_rdy,b_rdy,q1b,q2b, count
        vt[0]  = '{0, 0,0,0,        0,0,0,        0,0, 0,0,0,        0,0,0,0, 0}; // in reset
        vt[1]  = '{1, 0,0,0,        0,0,0,        0,0, 0,0,0,        1,1,0,0, 0}; // no write after release
        vt[2]  = '{1, 1,5,32'h11,   0,0,0,        5,0, 0,0,0,        1,1,1,0, 0}; // A x5
        vt[3]  = '{1, 0,0,0,        0,0,0,        5,0, 1,5,32'h11,   1,1,0,0, 1};
        vt[4]  = '{1, 0,0,0,        0,0,0,        5,0, 0,0,0,        1,1,0,0, 0};
        vt[5]  = '{1, 1,3,32'hA,    1,3,32'hB,    3,0, 0,0,0,        1,1,1,0, 0}; // dual x3
        vt[6]  = '{1, 0,0,0,        0,0,0,        3,0, 1,3,32'hA,    1,1,1,0, 2};
        vt[7]  = '{1, 0,0,0,        0,0,0,        3,0, 1,3,32'hB,    1,1,0,0, 1};
        vt[8]  = '{1, 0,0,0,        0,0,0,        3,0, 0,0,0,        1,1,0,0, 0};
        vt[9]  = '{1, 1,0,32'h55,   1,0,32'h66,   0,0, 0,0,0,        1,1,0,0, 0}; // x0 both
        vt[10] = '{1, 0,0,0,        0,0,0,        0,0, 0,0,0,        1,1,0,0, 0};
        vt[11] = '{1, 1,7,32'h77,   0,0,0,        0,7, 0,0,0,        1,1,0,1, 0}; // x7
        vt[12] = '{1, 0,0,0,        0,0,0,        0,7, 1,7,32'h77,   1,1,0,0, 1}; // x7 only at head
        vt[13] = '{1, 1,7,32'h70,   1,7,32'h71,   0,7, 0,0,0,        1,1,0,1, 0};
        vt[14] = '{1, 0,0,0,        0,0,0,        0,7, 1,7,32'h70,   1,1,0,1, 2}; // younger x7 queued
        vt[15] = '{1, 0,0,0,        0,0,0,        0,7, 1,7,32'h71,   1,1,0,0, 1};
        vt[16] = '{1, 1,1,32'h1,    1,2,32'h2,    0,0, 0,0,0,        1,1,0,0, 0};
        vt[17] = '{1, 1,3,32'h3,    1,4,32'h4,    0,0, 1,1,32'h1,    1,1,0,0, 2};
        vt[18] = '{1, 1,5,32'h5,    1,6,32'h6,    2,5, 1,2,32'h2,    1,0,0,1, 3}; // free=1: B waits
        vt[19] = '{1, 0,0,0,        1,6,32'h6,    5,3, 1,3,32'h3,    1,1,1,0, 3}; // free=1, A idle
        vt[20] = '{0, 0,0,0,        0,0,0,        5,6, 0,0,0,        0,0,0,0, 0}; // reset with 3 pending
        vt[21] = '{1, 0,0,0,        0,0,0,        5,6, 0,0,0,        1,1,0,0, 0};
        vt[22] = '{1, 1,5,32'h11,   0,0,0,        0,0, 0,0,0,        1,1,0,0, 0};
        vt[23] = '{1, 0,0,0,        0,0,0,        0,0, 1,5,32'h11,   1,1,0,0, 1};
        vt[24] = '{1, 0,0,0,        0,0,0,        0,0, 0,0,0,        1,1,0,0, 0};

        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            reset      = vt[i].rst_n;
            a_valid    = vt[i].av; a_address = vt[i].aa; a_data = vt[i].ad;
            b_valid    = vt[i].bv; b_address = vt[i].ba; b_data = vt[i].bd;
            q1_address = vt[i].q1; q2_address = vt[i].q2;
            #1;
            check($sformatf("vec%0d", i),
                  {15'd0, write, write_address, write_data, a_ready, b_ready, q1_busy, q2_busy, count},
                  {15'd0, vt[i].ew, vt[i].ewa, vt[i].ewd, vt[i].ear, vt[i].ebr, vt[i].eq1, vt[i].eq2, vt[i].ecnt});
            @(posedge clock); #1;
        end

        // Held-valid fill: both channels pushing continuously, then drain.
        idle_inputs();
        reset = 1'b1;
        na = 0; nb = 0; pushed = 0; retired = 0; peak = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            a_valid   = (cyc < 10);
            a_address = 5'((na % 31) + 1);
            a_data    = 32'hA000_0000 + 32'(na);
            b_valid   = (cyc < 14);
            b_address = 5'(((nb + 10) % 31) + 1);
            b_data    = 32'hB000_0000 + 32'(nb);
            #1;
            cm  = q.size();
            mar = (4 - cm) >= 1;
            mbr = ((4 - cm) >= 2) || (((4 - cm) >= 1) && !a_valid);
            if (cm != 0) it = q[0];
            else         it = '{5'd0, 32'd0};
            check($sformatf("fill%0d", cyc),
                  {21'd0, a_ready, b_ready, write, write_address, write_data, count},
                  {21'd0, mar, mbr, (cm != 0), it.addr, it.data, 3'(cm)});
            if (write) retired++;
            if (cm != 0) void'(q.pop_front());
            if (a_valid && mar) begin q.push_back('{a_address, a_data}); na++; pushed++; end
            if (b_valid && mbr) begin q.push_back('{b_address, b_data}); nb++; pushed++; end
            if (q.size() > peak) peak = q.size();
            @(posedge clock); #1;
        end
        idle_inputs();
        check("fill_retired", 64'(retired), 64'(pushed));
        check("fill_peak_le_depth", 64'(peak <= 4), 64'd1);
        check("fill_b_served", 64'(nb > 0), 64'd1);

        // DEPTH = 2: reach full, readiness drops while full, returns next cycle.
        d2_step("d2_c0", 1,1,32'hA1, 1,2,32'hB2, 1,1, 0,0,0,        2'd0);
        d2_step("d2_c1", 1,3,32'hC3, 1,4,32'hD4, 0,0, 1,1,32'hA1,   2'd2);
        d2_step("d2_c2", 1,3,32'hC3, 1,4,32'hD4, 1,0, 1,2,32'hB2,   2'd1);
        d2_step("d2_c3", 0,0,0,      1,4,32'hD4, 1,1, 1,3,32'hC3,   2'd1);
        d2_step("d2_c4", 0,0,0,      0,0,0,      1,1, 1,4,32'hD4,   2'd1);
        d2_step("d2_c5", 0,0,0,      0,0,0,      1,1, 0,0,0,        2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
